// File: rtl/ept_seq_alu.sv
// ept_seq_alu: opcode-selected WIDTH-bit arithmetic/logic unit with
// valid/ready handshakes on both sides and a registered result.
// Single-cycle ops complete on the accepting edge. DIV/REM with a
// nonzero divisor run an iterative restoring divider, one quotient
// bit per cycle, for WIDTH cycles.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   OP_VALID/OP_READY operation handshake (OP_READY high only in IDLE)
//   OPCODE            4-bit operation select
//   OPERAND_A/_B      unsigned operands (B is also the shift amount)
//   RESULT_VALID/_READY result handshake
//   RESULT            registered result
//   FLAG_ZERO/_CARRY/_DIVZERO  registered status flags
module ept_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             OP_VALID,
    output logic             OP_READY,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] OPERAND_A,
    input  logic [WIDTH-1:0] OPERAND_B,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             FLAG_ZERO,
    output logic             FLAG_CARRY,
    output logic             FLAG_DIVZERO
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
        OP_REM  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7,
        OP_NAND = 4'h8, OP_NOR  = 4'h9, OP_XNOR = 4'hA, OP_NOT  = 4'hB,
        OP_SHL  = 4'hC, OP_SHR  = 4'hD, OP_MAX  = 4'hE, OP_EQ   = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int               CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             valid_q, zero_q, carry_q, divzero_q;
    logic [WIDTH-1:0] div_rem_q, div_quo_q, div_b_q;
    logic [CW-1:0]    cnt_q;
    logic             is_rem_q;

    // Single-cycle datapath, evaluated on the live inputs at accept.
    op_e              op;
    logic [WIDTH:0]   sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] alu_res_d;
    logic             alu_carry_d, alu_dz_d;
    logic             start_div;

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path through the case can leave it unassigned and infer a latch.
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
        alu_dz_d    = 1'b0;
        op   = op_e'(OPCODE);
        sum  = {1'b0, OPERAND_A} + {1'b0, OPERAND_B};
        diff = {1'b0, OPERAND_A} - {1'b0, OPERAND_B};
        prod = {{WIDTH{1'b0}}, OPERAND_A} * {{WIDTH{1'b0}}, OPERAND_B};
        case (op)
            OP_ADD:  begin alu_res_d = sum[WIDTH-1:0];  alu_carry_d = sum[WIDTH];  end
            OP_SUB:  begin alu_res_d = diff[WIDTH-1:0]; alu_carry_d = diff[WIDTH]; end
            OP_MUL:  begin
                alu_res_d   = prod[WIDTH-1:0];
                alu_carry_d = |prod[2*WIDTH-1:WIDTH];
            end
            // Only the divide-by-zero case completes here; nonzero divisors
            // go to the iterative divider.
            OP_DIV:  begin alu_res_d = '1;        alu_dz_d = (OPERAND_B == '0); end
            OP_REM:  begin alu_res_d = OPERAND_A; alu_dz_d = (OPERAND_B == '0); end
            OP_AND:  alu_res_d = OPERAND_A & OPERAND_B;
            OP_OR:   alu_res_d = OPERAND_A | OPERAND_B;
            OP_XOR:  alu_res_d = OPERAND_A ^ OPERAND_B;
            OP_NAND: alu_res_d = ~(OPERAND_A & OPERAND_B);
            OP_NOR:  alu_res_d = ~(OPERAND_A | OPERAND_B);
            OP_XNOR: alu_res_d = ~(OPERAND_A ^ OPERAND_B);
            OP_NOT:  alu_res_d = ~OPERAND_A;
            OP_SHL:  alu_res_d = (OPERAND_B >= W_VAL) ? '0 : (OPERAND_A << OPERAND_B);
            OP_SHR:  alu_res_d = (OPERAND_B >= W_VAL) ? '0 : (OPERAND_A >> OPERAND_B);
            OP_MAX:  alu_res_d = (OPERAND_A > OPERAND_B) ? OPERAND_A : OPERAND_B;
            OP_EQ:   alu_res_d = (OPERAND_A == OPERAND_B) ? '1 : '0;
            default: alu_res_d = '0;
        endcase
        start_div = ((op == OP_DIV) || (op == OP_REM)) && (OPERAND_B != '0);
    end

    // One restoring-divider step. The dividend is held in the quotient
    // register and shifted out MSB first while quotient bits shift in.
    logic [WIDTH:0]   rem_shift, trial;
    logic [WIDTH-1:0] div_rem_d, div_quo_d;

    always_comb begin
        rem_shift = {div_rem_q, div_quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, div_b_q};
        // Partial remainder is always below the divisor, so the top bit of
        // the trial subtract is set exactly when it would go negative.
        if (trial[WIDTH]) begin
            div_rem_d = rem_shift[WIDTH-1:0];
            div_quo_d = {div_quo_q[WIDTH-2:0], 1'b0};
        end else begin
            div_rem_d = trial[WIDTH-1:0];
            div_quo_d = {div_quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            valid_q   <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            divzero_q <= 1'b0;
            div_rem_q <= '0;
            div_quo_q <= '0;
            div_b_q   <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (OP_VALID) begin
                        if (start_div) begin
                            div_rem_q <= '0;
                            div_quo_q <= OPERAND_A;
                            div_b_q   <= OPERAND_B;
                            is_rem_q  <= (op == OP_REM);
                            cnt_q     <= CNT_INIT;
                            state_q   <= S_EXEC;
                        end else begin
                            result_q  <= alu_res_d;
                            zero_q    <= (alu_res_d == '0);
                            carry_q   <= alu_carry_d;
                            divzero_q <= alu_dz_d;
                            valid_q   <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    div_rem_q <= div_rem_d;
                    div_quo_q <= div_quo_d;
                    cnt_q     <= cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        result_q  <= is_rem_q ? div_rem_d : div_quo_d;
                        zero_q    <= ((is_rem_q ? div_rem_d : div_quo_d) == '0);
                        carry_q   <= 1'b0;
                        divzero_q <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (RESULT_READY) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign OP_READY     = (state_q == S_IDLE) && !RST;
    assign RESULT_VALID = valid_q;
    assign RESULT       = result_q;
    assign FLAG_ZERO    = zero_q;
    assign FLAG_CARRY   = carry_q;
    assign FLAG_DIVZERO = divzero_q;

endmodule

// File: tb/tb_ept_seq_alu.sv
// Directed self-checking bench for ept_seq_alu at WIDTH=8.
module tb_ept_seq_alu;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MUL = 4'h2, DIV = 4'h3,
                           REM = 4'h4, AND_ = 4'h5, OR_ = 4'h6, XOR_ = 4'h7,
                           NAND_ = 4'h8, NOR_ = 4'h9, XNOR_ = 4'hA, NOT_ = 4'hB,
                           SHL = 4'hC, SHR = 4'hD, MAX = 4'hE, EQ = 4'hF;

    logic       CLK = 1'b0;
    logic       RST;
    logic       OP_VALID;
    logic       OP_READY;
    logic [3:0] OPCODE;
    logic [7:0] OPERAND_A, OPERAND_B;
    logic       RESULT_VALID;
    logic       RESULT_READY;
    logic [7:0] RESULT;
    logic       FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO;

    int vectors = 0;
    int miscompares = 0;

    ept_seq_alu #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OPCODE(OPCODE), .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B),
        .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY),
        .RESULT(RESULT), .FLAG_ZERO(FLAG_ZERO), .FLAG_CARRY(FLAG_CARRY),
        .FLAG_DIVZERO(FLAG_DIVZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, res;
        logic       z, c, dz;
    } vec_t;

    vec_t vecs [22];

    // Present one op for exactly one rising edge, then withdraw OP_VALID.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        OPCODE = op; OPERAND_A = a; OPERAND_B = b; OP_VALID = 1'b1;
        @(posedge CLK);
        #1 OP_VALID = 1'b0;
    endtask

    task automatic ack();
        @(negedge CLK);
        RESULT_READY = 1'b1;
        @(posedge CLK);
        #1 RESULT_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; OP_VALID = 1'b0; RESULT_READY = 1'b0;
        OPCODE = '0; OPERAND_A = '0; OPERAND_B = '0;
        #1;
        vectors++;
        if ({OP_READY, RESULT_VALID, RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b c=%b dz=%b, want all 0",
                     OP_READY, RESULT_VALID, RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        vectors++;
        if (OP_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", OP_READY);
        end
    endtask

    task automatic test_alu_ops();
        vecs[0]  = '{ADD,   8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{SUB,   8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{SUB,   8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{MUL,   8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{MAX,   8'h7F, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{EQ,    8'h5A, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{EQ,    8'h5A, 8'h5B, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{SHL,   8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{SHR,   8'h81, 8'h09, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{SHR,   8'h81, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{SHL,   8'h01, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{AND_,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OR_,   8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{XOR_,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{NAND_, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{NOR_,  8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{XNOR_, 8'hA5, 8'hA4, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{NOT_,  8'h0F, 8'h99, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{DIV,   8'h55, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{REM,   8'h55, 8'h00, 8'h55, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{ADD,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{MUL,   8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0};
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge CLK);
            vectors++;
            if ({RESULT_VALID, RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO} !==
                {1'b1, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].dz}) begin
                miscompares++;
                $display("FAIL op%0d(%h %h,%h): got vld=%b res=%h z=%b c=%b dz=%b, want vld=1 res=%h z=%b c=%b dz=%b",
                         i, vecs[i].op, vecs[i].a, vecs[i].b, RESULT_VALID, RESULT,
                         FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO,
                         vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].dz);
            end
            ack();
            @(negedge CLK);
            vectors++;
            if ({RESULT_VALID, OP_READY, RESULT} !== {2'b01, vecs[i].res}) begin
                miscompares++;
                $display("FAIL op%0d_after_ack: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=%h",
                         i, RESULT_VALID, OP_READY, RESULT, vecs[i].res);
            end
        end
    endtask

    task automatic test_div(input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] exp);
        send(op, a, b);
        @(negedge CLK);
        vectors++;
        if ({OP_READY, RESULT_VALID} !== 2'b00) begin
            miscompares++;
            $display("FAIL div_%h_%h_start: got rdy=%b vld=%b, want 0 0", a, b, OP_READY, RESULT_VALID);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            vectors++;
            if ({OP_READY, RESULT_VALID} !== {1'b0, (k == 8)}) begin
                miscompares++;
                $display("FAIL div_%h_%h_edge%0d: got rdy=%b vld=%b, want rdy=0 vld=%b",
                         a, b, k, OP_READY, RESULT_VALID, (k == 8));
            end
        end
        vectors++;
        if ({RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO} !== {exp, (exp == 8'h00), 2'b00}) begin
            miscompares++;
            $display("FAIL div_%h_%h_result: got res=%h z=%b c=%b dz=%b, want res=%h z=%b c=0 dz=0",
                     a, b, RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO, exp, (exp == 8'h00));
        end
        ack();
    endtask

    task automatic test_backpressure();
        send(ADD, 8'h12, 8'h34);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            vectors++;
            if ({RESULT_VALID, OP_READY, RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO} !==
                {2'b10, 8'h46, 3'b000}) begin
                miscompares++;
                $display("FAIL backpressure_hold%0d: got vld=%b rdy=%b res=%h z=%b c=%b dz=%b, want vld=1 rdy=0 res=46 flags 0",
                         k, RESULT_VALID, OP_READY, RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO);
            end
            OP_VALID  = 1'b1;
            OPCODE    = (k % 2 == 0) ? SUB : DIV;
            OPERAND_A = 8'h10 + 8'(k);
            OPERAND_B = 8'h20 - 8'(k);
        end
        @(negedge CLK);
        OP_VALID = 1'b0;
        RESULT_READY = 1'b1;
        @(posedge CLK);
        #1 RESULT_READY = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({RESULT_VALID, OP_READY, RESULT} !== {2'b01, 8'h46}) begin
            miscompares++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=46",
                     RESULT_VALID, OP_READY, RESULT);
        end
    endtask

    // RESULT_READY already high when the result appears: handshake on the next edge.
    task automatic test_back_to_back();
        @(negedge CLK);
        RESULT_READY = 1'b1;
        send(ADD, 8'h01, 8'h02);
        @(negedge CLK);
        vectors++;
        if ({RESULT_VALID, OP_READY, RESULT} !== {2'b10, 8'h03}) begin
            miscompares++;
            $display("FAIL early_ready_valid: got vld=%b rdy=%b res=%h, want vld=1 rdy=0 res=03",
                     RESULT_VALID, OP_READY, RESULT);
        end
        @(negedge CLK);
        vectors++;
        if ({RESULT_VALID, OP_READY} !== 2'b01) begin
            miscompares++;
            $display("FAIL early_ready_handshake: got vld=%b rdy=%b, want vld=0 rdy=1",
                     RESULT_VALID, OP_READY);
        end
        RESULT_READY = 1'b0;
        // Accept on the edge right after the handshake edge.
        send(SUB, 8'h10, 8'h01);
        @(negedge CLK);
        vectors++;
        if ({RESULT_VALID, RESULT} !== {1'b1, 8'h0F}) begin
            miscompares++;
            $display("FAIL back_to_back: got vld=%b res=%h, want vld=1 res=0F", RESULT_VALID, RESULT);
        end
        ack();
    endtask

    task automatic test_reset_mid_exec();
        send(ADD, 8'hF0, 8'h20);
        ack();
        send(DIV, 8'hC8, 8'h07);
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        vectors++;
        if ({OP_READY, RESULT_VALID, RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_mid_exec: got rdy=%b vld=%b res=%h z=%b c=%b dz=%b, want all 0",
                     OP_READY, RESULT_VALID, RESULT, FLAG_ZERO, FLAG_CARRY, FLAG_DIVZERO);
        end
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({OP_READY, RESULT_VALID, RESULT} !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_held: got rdy=%b vld=%b res=%h, want 0 0 00", OP_READY, RESULT_VALID, RESULT);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if ({OP_READY, RESULT_VALID, RESULT} !== {2'b10, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_abort_no_result: got rdy=%b vld=%b res=%h, want rdy=1 vld=0 res=00",
                     OP_READY, RESULT_VALID, RESULT);
        end
        send(ADD, 8'h01, 8'h01);
        @(negedge CLK);
        vectors++;
        if ({RESULT_VALID, RESULT, FLAG_ZERO, FLAG_CARRY} !== {1'b1, 8'h02, 2'b00}) begin
            miscompares++;
            $display("FAIL post_reset_add: got vld=%b res=%h z=%b c=%b, want vld=1 res=02 z=0 c=0",
                     RESULT_VALID, RESULT, FLAG_ZERO, FLAG_CARRY);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_div(DIV, 8'hC8, 8'h07, 8'h1C);
        test_div(REM, 8'hC8, 8'h07, 8'h04);
        test_div(DIV, 8'hFF, 8'h01, 8'hFF);
        test_div(DIV, 8'h07, 8'hC8, 8'h00);
        test_div(REM, 8'hFF, 8'h10, 8'h0F);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ept_seq_alu.md
# ept_seq_alu

Parametrised, clocked arithmetic/logic unit for the EPT MAX10 operator designs. It replaces fixed 8-bit combinational operator outputs with a single opcode-selected datapath of WIDTH bits. Operands are accepted through a valid/ready handshake and results are returned through a valid/ready handshake, with registered result and flags. Divide and remainder use an iterative restoring divider, so the block suits small MAX10 devices. It sits between the host-side register interface and user logic.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 4 to 32.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- OP_VALID  in  1  an operation is presented on OPCODE/OPERAND_A/OPERAND_B.
- OP_READY  out  1  block is idle and can accept an operation.
- OPCODE  in  4  operation select (map in Operation).
- OPERAND_A  in  WIDTH  first operand, unsigned.
- OPERAND_B  in  WIDTH  second operand, unsigned; also the shift amount.
- RESULT_VALID  out  1  RESULT/flags hold a completed operation.
- RESULT_READY  in  1  consumer accepts the result.
- RESULT  out  WIDTH  registered result.
- FLAG_ZERO  out  1  RESULT == 0.
- FLAG_CARRY  out  1  ADD carry-out, SUB borrow, MUL high half nonzero; 0 for all other ops.
- FLAG_DIVZERO  out  1  DIV/REM with OPERAND_B == 0.

## Operation
- Opcode map:
  - 0 ADD, 1 SUB (A-B), 2 MUL (low WIDTH bits), 3 DIV (quotient), 4 REM (remainder).
  - 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, A XNOR, B NOT (~A; B ignored).
  - C SHL (A<<B), D SHR (A>>B, logical), E MAX (unsigned larger of A,B), F EQ (all ones if A==B, else 0).
- Shifts: if B >= WIDTH, the result is 0.
- States:
  - IDLE -> DONE on accept of any non-divide op, or of DIV/REM with B==0.
  - IDLE -> EXEC on accept of DIV/REM with B!=0.
  - EXEC -> DONE after WIDTH iterations.
  - DONE -> IDLE when RESULT_READY is sampled high.
- Accept = OP_VALID && OP_READY at a rising edge. OP_READY = (state==IDLE) && !RST.
- Opcode and operands are captured at accept. Later input changes have no effect on the operation in flight.
- Divider:
  - Restoring, MSB first, one quotient bit per EXEC cycle.
  - Iteration counter counts WIDTH down to 0.
  - Remainder and quotient registers are each WIDTH bits, plus a WIDTH+1-bit trial subtract.
- Divide by zero: DIV returns all ones, REM returns A, FLAG_DIVZERO=1, CARRY=0, no EXEC cycles.
- In DONE, RESULT and the flags are held stable until the handshake completes.
- After the handshake, RESULT and the flags keep their last value and RESULT_VALID=0.
- OP_VALID outside IDLE is ignored; nothing is queued.

## Timing
- Reset values (immediately on RST assert, independent of CLK):
  - state=IDLE.
  - RESULT=0, RESULT_VALID=0, all flags 0, divider registers 0.
  - OP_READY=0 while RST is high; OP_READY=1 from the first cycle after deassert.
- Non-divide op accepted at edge E: RESULT, flags and RESULT_VALID=1 update at E, visible in the cycle after E. Latency is 1 cycle.
- DIV/REM (B!=0) accepted at edge E: EXEC spans edges E+1..E+WIDTH. RESULT_VALID rises at E+WIDTH (8 cycles for WIDTH=8). OP_READY is low from E onward.
- RESULT_READY sampled high at edge D (RESULT_VALID=1): RESULT_VALID falls at D and OP_READY rises at D.
  - The earliest next accept is edge D+1.
  - Maximum throughput is one op per 2 cycles.
- RESULT_READY high in the same cycle RESULT_VALID rises is honoured on the next edge; the result is never dropped.
- RST mid-EXEC or mid-DONE: the operation is aborted with no result output, and all outputs take their reset values.
- All arithmetic is unsigned and modulo 2^WIDTH. ADD/SUB are computed at WIDTH+1 bits to derive CARRY. MUL is computed at 2*WIDTH bits.

## Test plan
- ADD A=0xF0,B=0x20 (WIDTH=8) -> RESULT=0x10, CARRY=1, ZERO=0, RESULT_VALID one cycle after accept. SUB 0x03-0x05 -> 0xFE, CARRY=1. SUB 0x05-0x05 -> 0x00, ZERO=1.
- MUL 0x10*0x11 -> RESULT=0x10, CARRY=1. MAX 0x7F,0x80 -> 0x80. EQ 0x5A,0x5A -> 0xFF. SHL 0x81 by 1 -> 0x02. SHR 0x81 by 9 -> 0x00, ZERO=1.
- DIV 200/7 -> 0x1C, RESULT_VALID exactly 8 edges after accept, OP_READY low throughout. REM 200%7 -> 0x04. DIV 0xFF/0x01 -> 0xFF.
- DIV 0x55/0x00 -> RESULT=0xFF, DIVZERO=1, 1-cycle latency. REM 0x55/0x00 -> 0x55, DIVZERO=1.
- Backpressure: hold RESULT_READY low 5 cycles after RESULT_VALID and change the operands and OP_VALID meanwhile. RESULT and flags must stay stable, OP_READY must stay 0, and no op is accepted. Raising RESULT_READY -> OP_READY=1 next cycle.
- Assert RST in the 4th EXEC cycle of DIV 200/7 -> all outputs 0 at once, OP_READY=0 during reset. After deassert, ADD 1+1 -> 0x02 with normal latency.
